// File: rtl/fifo_wr_arbiter.sv
// Write side of the dual-clock FIFO: round-robin arbitration with packet locking over one
// write port, plus the binary/Gray write pointer, full flag and fill level in the wclk domain.
module fifo_wr_arbiter #(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  output logic                  wen,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]     wptr,
  output logic                  wfull,
  output logic [ADDRSIZE:0]     wlevel,
  output logic [IDW-1:0]        owner,
  output logic                  locked
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [IDW-1:0]      owner_r, owner_nxt_s, gnt_id_s, rr_id_s;
  logic [NREQ-1:0]     gnt_s;
  logic                rr_found_s, gnt_last_s, wen_s, wfull_nxt_s;
  logic [ADDRSIZE:0]   wbin_r, wptr_r, wlevel_r;
  logic [ADDRSIZE:0]   wbin_nxt_s, wgray_nxt_s, rbin_s;
  logic                wfull_r;

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Grant selection: locked owner only, otherwise first requester after the last owner
  always_comb begin
    gnt_s      = '0;
    gnt_id_s   = owner_r;
    rr_found_s = 1'b0;
    rr_id_s    = owner_r;
    if (!wrst_n || wfull_r) begin
      gnt_s = '0;
    end else if (state_r == LOCK) begin
      gnt_s[owner_r] = req[owner_r];
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        rr_id_s = IDW'((int'(owner_r) + k) % NREQ);
        if (!rr_found_s && req[rr_id_s]) begin
          rr_found_s     = 1'b1;
          gnt_s[rr_id_s] = 1'b1;
          gnt_id_s       = rr_id_s;
        end else begin
          rr_found_s = rr_found_s;
        end
      end
    end
  end

  assign wen_s       = |gnt_s;
  assign gnt_last_s  = req_last[gnt_id_s];
  assign wbin_nxt_s  = wbin_r + {{ADDRSIZE{1'b0}}, wen_s};
  assign wgray_nxt_s = bin2gray(wbin_nxt_s);
  assign rbin_s      = gray2bin(wq2_rptr);
  // Full when the write pointer is exactly one lap ahead of the synchronized read pointer
  assign wfull_nxt_s = (wgray_nxt_s == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  // Lock state and owner advance only on accepted words
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    if (wen_s) begin
      case (state_r)
        IDLE: begin
          owner_nxt_s = gnt_id_s;
          state_nxt_s = gnt_last_s ? IDLE : LOCK;
        end
        LOCK:    state_nxt_s = gnt_last_s ? IDLE : LOCK;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, pointer, full and level registers
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_r  <= IDLE;
      owner_r  <= IDW'(NREQ - 1);
      wbin_r   <= '0;
      wptr_r   <= '0;
      wfull_r  <= 1'b0;
      wlevel_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      wbin_r   <= wbin_nxt_s;
      wptr_r   <= wgray_nxt_s;
      wfull_r  <= wfull_nxt_s;
      wlevel_r <= wbin_nxt_s - rbin_s;
    end
  end

  assign gnt    = gnt_s;
  assign wen    = wen_s;
  assign waddr  = wbin_r[ADDRSIZE-1:0];
  assign wdata  = wen_s ? req_data[int'(gnt_id_s)*DSIZE +: DSIZE] : {DSIZE{1'b0}};
  assign wptr   = wptr_r;
  assign wfull  = wfull_r;
  assign wlevel = wlevel_r;
  assign owner  = owner_r;
  assign locked = (state_r == LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a 4-entry FIFO and four requesters.
module tb_fifo_wr_arbiter;
  localparam int ADDRSIZE = 2;
  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req, req_last, gnt;
  logic [31:0] req_data;
  logic [2:0]  wq2_rptr, wptr, wlevel;
  logic        wen, wfull, locked;
  logic [1:0]  waddr, owner;
  logic [7:0]  wdata;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE), .NREQ(NREQ)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wptr(wptr), .wfull(wfull), .wlevel(wlevel), .owner(owner), .locked(locked)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  act_q[$];
  int   tests = 0;
  int   fails = 0;
  int   stepn = 0;

  // reference model state
  logic [1:0] m_owner = 2'd3;
  logic       m_lock  = 1'b0;
  logic [2:0] m_wbin  = 3'd0;
  logic [2:0] m_wptr  = 3'd0;
  logic [2:0] m_wlevel = 3'd0;
  logic       m_wfull = 1'b0;

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    logic [2:0] g;
    g[2] = b[2];
    for (int i = 0; i < 2; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [2:0] from_gray(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    for (int i = 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One clock: predict the grant, record the DUT write, then advance the model at the edge.
  task automatic step();
    logic       hit;
    logic [1:0] gsel, j;
    logic [2:0] nb;
    wr_t        e, a;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'(i * 64 + stepn);
    stepn++;
    #1;
    hit  = 1'b0;
    gsel = 2'd0;
    if (wrst_n && !m_wfull) begin
      if (m_lock) begin
        hit  = req[m_owner];
        gsel = m_owner;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          j = 2'(int'(m_owner) + k);
          if (!hit && req[j]) begin
            hit  = 1'b1;
            gsel = j;
          end
        end
      end
    end
    if (hit) begin
      e.g = 4'b0001 << gsel;
      e.a = m_wbin[1:0];
      e.d = req_data[int'(gsel)*8 +: 8];
      exp_q.push_back(e);
    end
    @(negedge wclk);
    if (wen === 1'b1 || gnt !== 4'b0000) begin
      a.g = gnt;
      a.a = waddr;
      a.d = wdata;
      act_q.push_back(a);
    end
    @(posedge wclk);
    if (!wrst_n) begin
      m_wbin = 3'd0; m_wptr = 3'd0; m_wfull = 1'b0; m_wlevel = 3'd0;
      m_owner = 2'd3; m_lock = 1'b0;
    end else begin
      nb       = m_wbin + (hit ? 3'd1 : 3'd0);
      m_wptr   = to_gray(nb);
      m_wlevel = nb - from_gray(wq2_rptr);
      m_wfull  = (m_wlevel == 3'd4);
      m_wbin   = nb;
      if (hit) begin
        if (!m_lock) m_owner = gsel;
        m_lock = !req_last[gsel];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; req = 4'hF; req_last = 4'hF; wq2_rptr = 3'd0;
    step(); step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    tests++; if (wen !== 1'b0) begin fails++; $display("FAIL rst_wen: got %b want 0", wen); end
    tests++; if (wptr !== 3'd0) begin fails++; $display("FAIL rst_wptr: got %0d want 0", wptr); end
    tests++; if (wfull !== 1'b0) begin fails++; $display("FAIL rst_wfull: got %b want 0", wfull); end
    tests++; if (wlevel !== 3'd0) begin fails++; $display("FAIL rst_wlevel: got %0d want 0", wlevel); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %b want 0", locked); end
    tests++; if (owner !== 2'd3) begin fails++; $display("FAIL rst_owner: got %0d want 3", owner); end
    tests++; if (act_q.size() != 0) begin fails++; $display("FAIL rst_writes: got %0d want 0", act_q.size()); end
    exp_q.delete(); act_q.delete();
    wrst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] g_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    wr_t e, a;
    req = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wq2_rptr = to_gray(m_wbin);
      step();
    end
    tests++;
    if (act_q.size() != 5 || exp_q.size() != 5) begin
      fails++; $display("FAIL rr_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < 5 && act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      tests++;
      if (a !== e || a.g !== g_exp[i] || a.a !== 2'(i)) begin
        fails++;
        $display("FAIL rr_wr%0d: got g=%b a=%0d d=%h want g=%b a=%0d d=%h", i, a.g, a.a, a.d, g_exp[i], 2'(i), e.d);
      end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_lock();
    logic [3:0] last_v [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0110};
    logic [3:0] g_exp  [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic       lk_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    wr_t e, a;
    req = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      req_last = last_v[i];
      wq2_rptr = to_gray(m_wbin);
      step();
      tests++;
      if (locked !== lk_exp[i]) begin fails++; $display("FAIL lock_state%0d: got %b want %b", i, locked, lk_exp[i]); end
    end
    tests++;
    if (act_q.size() != 4 || exp_q.size() != 4) begin
      fails++; $display("FAIL lock_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < 4 && act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      tests++;
      if (a !== e || a.g !== g_exp[i]) begin
        fails++; $display("FAIL lock_wr%0d: got g=%b d=%h want g=%b d=%h", i, a.g, a.d, g_exp[i], e.d);
      end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_lock_stall();
    logic [3:0] req_v  [5] = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
    logic [3:0] last_v [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    logic       lk_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] g_exp  [3] = '{4'b0010, 4'b0010, 4'b0001};
    wr_t e, a;
    for (int i = 0; i < 5; i++) begin
      req = req_v[i]; req_last = last_v[i];
      wq2_rptr = to_gray(m_wbin);
      step();
      tests++;
      if (locked !== lk_exp[i]) begin fails++; $display("FAIL stall_lock%0d: got %b want %b", i, locked, lk_exp[i]); end
      if (i == 1 || i == 2) begin
        tests++;
        if (gnt !== 4'b0000) begin fails++; $display("FAIL stall_gnt%0d: got %b want 0000", i, gnt); end
      end
    end
    tests++;
    if (act_q.size() != 3 || exp_q.size() != 3) begin
      fails++; $display("FAIL stall_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3 && act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      tests++;
      if (a !== e || a.g !== g_exp[i]) begin
        fails++; $display("FAIL stall_wr%0d: got g=%b d=%h want g=%b d=%h", i, a.g, a.d, g_exp[i], e.d);
      end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_full();
    wr_t e, a;
    // open a packet, then reset mid-packet
    req = 4'b0100; req_last = 4'b0000; wq2_rptr = to_gray(m_wbin);
    step();
    wrst_n = 1'b0;
    step();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL midrst_locked: got %b want 0", locked); end
    wrst_n = 1'b1; req = 4'hF; req_last = 4'hF; wq2_rptr = 3'd0;
    exp_q.delete(); act_q.delete();
    for (int i = 0; i < 4; i++) step();
    tests++; if (wfull !== 1'b1) begin fails++; $display("FAIL full_flag: got %b want 1", wfull); end
    tests++; if (wlevel !== 3'd4) begin fails++; $display("FAIL full_level: got %0d want 4", wlevel); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      tests++; if (a !== e) begin fails++; $display("FAIL full_wr: got g=%b a=%0d want g=%b a=%0d", a.g, a.a, e.g, e.a); end
    end
    step();
    tests++; if (act_q.size() != 0 || gnt !== 4'b0000) begin fails++; $display("FAIL full_block: got %0d writes gnt=%b want 0 0000", act_q.size(), gnt); end
    wq2_rptr = 3'b001;
    step();
    tests++; if (act_q.size() != 0) begin fails++; $display("FAIL full_hold: got %0d writes want 0", act_q.size()); end
    tests++; if (wfull !== 1'b0) begin fails++; $display("FAIL full_clear: got %b want 0", wfull); end
    tests++; if (wlevel !== 3'd3) begin fails++; $display("FAIL full_level3: got %0d want 3", wlevel); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_wrap();
    logic [2:0] rbin, prev;
    int writes = 0, wraps = 0, cyc = 0;
    wr_t e, a;
    rbin = from_gray(wq2_rptr);
    prev = wptr;
    req = 4'hF;
    while (writes < 40 && cyc < 400) begin
      if (rbin != m_wbin && $urandom_range(0, 1) == 1) rbin = rbin + 3'd1;
      wq2_rptr = to_gray(rbin);
      req_last = 4'($urandom_range(0, 15));
      step();
      cyc++;
      tests++;
      if (wptr !== m_wptr || wlevel !== m_wlevel || wfull !== m_wfull) begin
        fails++;
        $display("FAIL wrap_ptr%0d: got p=%b l=%0d f=%b want p=%b l=%0d f=%b", cyc, wptr, wlevel, wfull, m_wptr, m_wlevel, m_wfull);
      end
      tests++;
      if ($countones(wptr ^ prev) > 1 || wlevel > 3'd4) begin
        fails++; $display("FAIL wrap_gray%0d: got prev=%b now=%b lvl=%0d want 1-bit step lvl<=4", cyc, prev, wptr, wlevel);
      end
      if (prev == 3'b100 && wptr == 3'b000) wraps++;
      prev = wptr;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        writes++;
        tests++; if (a !== e) begin fails++; $display("FAIL wrap_wr%0d: got g=%b a=%0d d=%h want g=%b a=%0d d=%h", writes, a.g, a.a, a.d, e.g, e.a, e.d); end
      end
      if (act_q.size() != exp_q.size()) begin
        tests++; fails++;
        $display("FAIL wrap_count%0d: got %0d want %0d", cyc, act_q.size(), exp_q.size());
        exp_q.delete(); act_q.delete();
      end
    end
    tests++; if (writes < 40) begin fails++; $display("FAIL wrap_budget: got %0d writes want 40", writes); end
    tests++; if (wraps == 0) begin fails++; $display("FAIL wrap_seen: got %0d wraps want >0", wraps); end
  endtask

  initial begin
    req_data = 32'h0;
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_stall();
    test_full();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
